// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and its tx_asm transmitter peer):
//   rx_state_t    - receiver FSM state type
//   BITS_PER_BYTE - payload bits covered by one per-byte parity bit
//   even_parity() - parity bit for one byte (XOR of its bits)
//   nparity()     - number of parity bits in a frame for a given word width/mode
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] b);
      return ^b;
   endfunction

   function automatic int nparity(input int data_width, input logic per_byte);
      return per_byte ? data_width / BITS_PER_BYTE : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter with a one-cycle sample tick.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : hold the counter at zero (no tick while held)
//   half       : tick after CLKS_PER_BIT/2 cycles instead of CLKS_PER_BIT
//   tick       : one-cycle pulse at the end of each (half) period
// The counter reloads itself on tick, so consecutive periods chain with no gap.
// -----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic half,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [CW-1:0] cnt;

   assign tick = !clear && (cnt == (half ? HALF_LAST : FULL_LAST));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) cnt <= '0;
      else if (tick)       cnt <= '0;
      else                 cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_asm.sv
// -----------------------------------------------------------------------------
// uart_rx_asm
// UART receiver: start bit, DATA_WIDTH data bits LSB first with even parity
// (one bit per byte or one per word), stop bit. Delivers the word with a
// one-cycle valid pulse; error flags any parity mismatch or a low stop bit.
//   clk, rst_n      : clock, synchronous active-low reset
//   rx_in           : serial line, idles high
//   parity_per_byte : 1 = parity after each byte, 0 = one parity after word
//                     (latched at the start edge for the whole frame)
//   valid           : one-cycle pulse, data/error updated
//   data            : received word (held until next valid)
//   error           : parity or framing error for the word (held likewise)
// Optional build macro UART_RX_SYNC_EN: pass rx_in through a 2-flop
// synchroniser (reset to 1) before use; adds 2 cycles of latency.
// -----------------------------------------------------------------------------
module uart_rx_asm
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic                  parity_per_byte,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  error
);

   localparam int NB = DATA_WIDTH / BITS_PER_BYTE;
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int PW = $clog2(NB + 1);

   if (DATA_WIDTH <= 0 || (DATA_WIDTH % BITS_PER_BYTE) != 0) begin : g_bad_width
      $error("uart_rx_asm: DATA_WIDTH must be a positive multiple of 8");
   end
   if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
      $error("uart_rx_asm: CLKS_PER_BIT must be even and >= 4");
   end

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], rx_in};
   end
   assign rx_s = sync_q[1];
`else
   assign rx_s = rx_in;
`endif

   rx_state_t             state;
   logic                  armed;
   logic                  per_byte_q;
   logic                  acc;
   logic                  err_q;
   logic [BW-1:0]         bit_cnt;
   logic [PW-1:0]         par_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  tick;

   // Timer is held in IDLE so the half-period count starts at the start edge.
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == IDLE),
      .half  (state == START),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         armed      <= 1'b0;
         per_byte_q <= 1'b0;
         acc        <= 1'b0;
         err_q      <= 1'b0;
         bit_cnt    <= '0;
         par_cnt    <= '0;
         shreg      <= '0;
         valid      <= 1'b0;
         data       <= '0;
         error      <= 1'b0;
      end else begin
         valid <= 1'b0;

         // A low stop bit means the line may be stuck low; refuse new starts
         // until it has been seen high again.
         if (state == STOP && tick && !rx_s) armed <= 1'b0;
         else if (rx_s)                      armed <= 1'b1;

         case (state)
            IDLE: begin
               if (armed && !rx_s) begin
                  state      <= START;
                  per_byte_q <= parity_per_byte;
                  bit_cnt    <= '0;
                  par_cnt    <= '0;
                  acc        <= 1'b0;
                  err_q      <= 1'b0;
               end
            end
            START: begin
               if (tick) state <= rx_s ? IDLE : DATA;
            end
            DATA: begin
               if (tick) begin
                  shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
                  acc     <= acc ^ rx_s;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (per_byte_q ? (bit_cnt[2:0] == 3'd7)
                                 : (bit_cnt == BW'(DATA_WIDTH - 1)))
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (tick) begin
                  if (rx_s != acc) err_q <= 1'b1;
                  acc     <= 1'b0;
                  par_cnt <= par_cnt + 1'b1;
                  if (par_cnt == PW'(nparity(DATA_WIDTH, per_byte_q) - 1))
                     state <= STOP;
                  else
                     state <= DATA;
               end
            end
            STOP: begin
               if (tick) begin
                  state <= IDLE;
                  valid <= 1'b1;
                  data  <= shreg;
                  error <= err_q | !rx_s;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_asm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_asm
// Bench for uart_rx_asm: a table of directed frames, hand-written corner
// sequences (bad stop, glitch, mid-frame reset) and random frames checked
// against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_asm;

   localparam int DW  = 32;
   localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_in = 1'b1;
   logic          parity_per_byte = 1'b0;
   logic          valid;
   logic [DW-1:0] data;
   logic          error;

   uart_rx_asm #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_in           (rx_in),
      .parity_per_byte (parity_per_byte),
      .valid           (valid),
      .data            (data),
      .error           (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            c;
      logic [DW-1:0] d;
      logic          e;
   } ev_t;
   ev_t evq[$];

   always @(negedge clk) if (valid) evq.push_back(ev_t'{cyc, data, error});

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serial frame as line levels, one entry per bit period.
   logic fbits[$];

   function automatic void build(input logic [DW-1:0] w, input logic pb,
                                 input int bad_par, input logic bad_stop);
      int k = 0;
      fbits.delete();
      fbits.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
         fbits.push_back(w[i]);
         if (pb && (i % 8) == 7) begin
            fbits.push_back((^w[i-7 +: 8]) ^ (k == bad_par));
            k++;
         end
      end
      if (!pb) fbits.push_back((^w) ^ (bad_par == 0));
      fbits.push_back(!bad_stop);
   endfunction

   // Reference decode of whatever is in fbits.
   function automatic void decode(input logic pb, output logic [DW-1:0] d, output logic e);
      int idx = 1;
      d = '0;
      e = 1'b0;
      for (int i = 0; i < DW; i++) begin
         d[i] = fbits[idx];
         idx++;
         if (pb && (i % 8) == 7) begin
            if (fbits[idx] != ^d[i-7 +: 8]) e = 1'b1;
            idx++;
         end
      end
      if (!pb) begin
         if (fbits[idx] != ^d) e = 1'b1;
         idx++;
      end
      if (!fbits[idx]) e = 1'b1;
   endfunction

   // Drive fbits; parity_per_byte is scrambled after the start bit to show
   // the mode is latched at the start edge.
   task automatic send(input logic pb, input int gap, input logic hold_low, output int fall);
      fall = cyc;
      parity_per_byte = pb;
      foreach (fbits[j]) begin
         rx_in = fbits[j];
         if (j == 1) parity_per_byte = 1'($urandom);
         tick_n(CPB);
      end
      rx_in = !hold_low;
      tick_n(gap);
   endtask

   task automatic check_frame(input string name, input int fall, input logic [DW-1:0] ed,
                              input logic ee, input int elat);
      chk({name, "_count"}, 64'(evq.size()), 64'd1);
      if (evq.size() >= 1) begin
         chk({name, "_data"}, 64'(evq[0].d), 64'(ed));
         chk({name, "_err"},  64'(evq[0].e), 64'(ee));
         chk({name, "_lat"},  64'(evq[0].c - fall), 64'(elat));
      end
      evq.delete();
   endtask

   typedef struct {
      logic [DW-1:0] w;
      logic          pb;
      int            bad_par;
      logic          exp_e;
      int            exp_lat;
   } vec_t;

   initial begin
      vec_t          vt[5];
      int            fall;
      logic [DW-1:0] ed;
      logic          ee;
      logic          pb;
      int            npar;

      vt[0] = vec_t'{32'hFCFCEEEB, 1'b1, -1, 1'b0, 601};
      vt[1] = vec_t'{32'hFCFCEEEB, 1'b0, -1, 1'b0, 553};
      vt[2] = vec_t'{32'hFCFCEEEB, 1'b1,  2, 1'b1, 601};
      vt[3] = vec_t'{32'hFCFCEEEB, 1'b1, -1, 1'b0, 601};
      vt[4] = vec_t'{32'hCAFEF00D, 1'b0,  0, 1'b1, 553};

      @(posedge clk);
      #1;
      tick_n(3);
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_data",  64'(data),  64'd0);
      chk("reset_error", 64'(error), 64'd0);
      rst_n = 1'b1;
      tick_n(4);

      // Directed table; gap 0 makes each frame follow its predecessor back to back.
      for (int v = 0; v < 5; v++) begin
         build(vt[v].w, vt[v].pb, vt[v].bad_par, 1'b0);
         send(vt[v].pb, 0, 1'b0, fall);
         check_frame($sformatf("vec%0d", v), fall, vt[v].w, vt[v].exp_e, vt[v].exp_lat + SYNC_LAT);
      end

      // Low stop bit, line stays low afterwards: no restart until it goes high.
      tick_n(3);
      build(32'h0F0F55AA, 1'b1, -1, 1'b1);
      send(1'b1, 0, 1'b1, fall);
      tick_n(100);
      check_frame("badstop", fall, 32'h0F0F55AA, 1'b1, 601 + SYNC_LAT);
      rx_in = 1'b1;
      tick_n(3);
      build(32'h12345678, 1'b1, -1, 1'b0);
      send(1'b1, 2, 1'b0, fall);
      check_frame("after_badstop", fall, 32'h12345678, 1'b0, 601 + SYNC_LAT);

      // Short glitch shorter than half a bit is a false start.
      rx_in = 1'b0;
      tick_n(5);
      rx_in = 1'b1;
      tick_n(40);
      chk("glitch_no_valid", 64'(evq.size()), 64'd0);
      build(32'h12345678, 1'b1, -1, 1'b0);
      send(1'b1, 2, 1'b0, fall);
      check_frame("after_glitch", fall, 32'h12345678, 1'b0, 601 + SYNC_LAT);

      // Reset in the middle of the data bits.
      build(32'hDEADBEEF, 1'b1, -1, 1'b0);
      parity_per_byte = 1'b1;
      for (int j = 0; j < 15; j++) begin
         rx_in = fbits[j];
         tick_n(CPB);
      end
      rx_in = 1'b1;
      rst_n = 1'b0;
      tick_n(2);
      chk("midreset_valid", 64'(valid), 64'd0);
      chk("midreset_data",  64'(data),  64'd0);
      chk("midreset_error", 64'(error), 64'd0);
      rst_n = 1'b1;
      tick_n(50);
      chk("midreset_no_valid", 64'(evq.size()), 64'd0);
      build(32'hA5A5A5A5, 1'b1, -1, 1'b0);
      send(1'b1, 2, 1'b0, fall);
      check_frame("after_reset", fall, 32'hA5A5A5A5, 1'b0, 601 + SYNC_LAT);

      // Random frames, some with one flipped data/parity bit.
      for (int r = 0; r < 20; r++) begin
         pb = 1'($urandom);
         build($urandom, pb, -1, 1'b0);
         if ($urandom_range(2) == 0) begin
            int fi = $urandom_range(fbits.size() - 2, 1);
            fbits[fi] = !fbits[fi];
         end
         decode(pb, ed, ee);
         npar = pb ? DW / 8 : 1;
         send(pb, $urandom_range(3), 1'b0, fall);
         check_frame($sformatf("rand%0d", r), fall, ed, ee,
                     CPB / 2 + (1 + DW + npar) * CPB + 1 + SYNC_LAT);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_asm.md
Name: uart_rx_asm

Overview:
- Serial UART receiver. Deserialises one DATA_WIDTH-bit word from the single-wire line `rx_in`.
- Checks even parity, either once per byte or once per word, and checks the stop bit.
- Presents the word with a one-cycle `valid` pulse and an `error` flag.
- Pairs with the team's tx_asm transmitter, which uses the same frame format and the same clock.

Parameters:
- DATA_WIDTH, 32, payload bits per frame. Must be a multiple of 8; elaboration fails otherwise.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be an even number ≥ 4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_in  in  1  serial line; idles high.
- parity_per_byte  in  1  1: one parity bit after each byte; 0: one parity bit after the whole word.
- valid  out  1  one-cycle pulse; a word is available.
- data  out  DATA_WIDTH  received word.
- error  out  1  qualifies the word presented with `valid`.

Behaviour:
- Frame on the line, in order:
  - start bit (0);
  - data bits, LSB of the word first;
  - parity bits;
  - stop bit (1).
- Parity placement:
  - per-byte mode: each byte's 8 bits (byte 0 first) are followed immediately by that byte's parity bit; DATA_WIDTH/8 parity bits total;
  - word mode: all data bits, then one parity bit.
- Even parity: parity bit = XOR of the covered data bits.
- Reset (rst_n=0 at a clock edge):
  - valid=0, data=0, error=0;
  - FSM to IDLE; all counters cleared;
  - applies mid-frame too; no output is produced for the aborted frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - armed only after `rx_in` has been sampled high at least once since reset or since a framing error;
  - armed and `rx_in`=0 → START; bit timer cleared; `parity_per_byte` latched for the whole frame (later changes ignored).
- START:
  - after CLKS_PER_BIT/2 cycles, sample `rx_in`;
  - 0 → DATA, bit timer restarts;
  - 1 → false start, back to IDLE, no output.
- DATA:
  - sample every CLKS_PER_BIT cycles (mid-bit);
  - shift into the word LSB-first and XOR into a running parity accumulator.
  - Per-byte mode: after each 8th bit → PARITY.
  - Word mode: after bit DATA_WIDTH → PARITY.
- PARITY:
  - sample one bit; mismatch with the accumulator sets the sticky frame error; accumulator clears.
  - Per-byte mode and more bytes remain → DATA; otherwise → STOP.
- STOP:
  - sample one bit; 0 sets the frame error and disarms IDLE.
  - On the same cycle: go to IDLE and register outputs, so `valid`=1 on the next cycle for exactly 1 cycle, with data = assembled word and error = sticky flag.
- Output hold: `data` and `error` hold their values until the next valid pulse. `valid` is never asserted on two consecutive cycles.
- Latency: `valid` rises CLKS_PER_BIT/2 + (1+DATA_WIDTH+NPAR)·CLKS_PER_BIT + 1 cycles after the falling edge is first seen.
  - NPAR = DATA_WIDTH/8 in per-byte mode, 1 in word mode.
  - Defaults, per-byte mode: 8 + 37·16 + 1 = 601 cycles.
- Back-to-back frames: a new start bit may begin right after the stop-bit sample; IDLE re-detects it with no gap required.
- Frames with errors still deliver `data` (best effort) with error=1.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - `rx_in` passes through a 2-flop synchroniser reset to 1;
  - all FSM sampling uses the synchronised signal;
  - latency grows by 2 cycles.
- Undefined: `rx_in` is used directly; the line is assumed already synchronous to `clk`.

Decomposition:
- Package uart_pkg:
  - state enum type rx_state_t;
  - localparam BITS_PER_BYTE=8;
  - function even_parity(byte) shared with tx_asm;
  - frame-length helper function nparity(DATA_WIDTH, per_byte).
- One sub-module, uart_bit_timer:
  - counts to CLKS_PER_BIT, with a half-period option for START;
  - emits a one-cycle sample tick;
  - inputs: clear, half.

Test Plan:
- Per-byte parity: loopback from tx_asm with data 0xFCFCEEEB, parity_per_byte=1 → single valid pulse, data=0xFCFCEEEB, error=0, 601 cycles after the start edge.
- Word parity: same word with parity_per_byte=0 → data=0xFCFCEEEB, error=0; frame is 35 bits, so latency = 8 + 34·16 + 1 = 553 cycles.
- Corrupted parity:
  - inverted parity bit of byte 2 (drive tx_asm error=1, or force the line) → data=0xFCFCEEEB, error=1;
  - clean frame immediately after → error=0.
- Stop bit driven 0 → valid with error=1; no new frame accepted until `rx_in` returns high.
- Glitch: `rx_in` low for 5 cycles (< CLKS_PER_BIT/2) → no valid; a following good frame 0x12345678 is received correctly.
- Reset: rst_n=0 for 2 cycles mid-DATA → valid/data/error = 0/0/0; no valid for the aborted frame; next frame 0xA5A5A5A5 received with error=0.
